// File: rtl/fp16_pkg.sv
// Shared types and constants for the FP16 operand feeder.
// Pair layout, default widths and FSM encodings.
package fp16_pkg;

    localparam int FP16_W = 16;
    localparam int LEN_W  = 11;

    localparam int PAIR_LAST_BIT  = 0;
    localparam int PAIR_FIRST_BIT = 1;
    localparam int PAIR_B_LSB     = 2;
    localparam int PAIR_A_LSB     = PAIR_B_LSB + FP16_W;
    localparam int PAIR_W         = PAIR_A_LSB + FP16_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/fp16_pair_skid.sv
// Two-entry buffer of operand pairs between the FIFO read port and the MAC.
// Simultaneous push and pop leave the count unchanged.
module fp16_pair_skid
    import fp16_pkg::*;
#(
    parameter int W = PAIR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   cnt_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign dout_o = mem_q[rd_q];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/fp16_operand_feeder.sv
// Pops FIFO A and B in lockstep and feeds tagged operand pairs to the MAC.
// Tracks issued/delivered counts for one programmed vector at a time.
module fp16_operand_feeder
    import fp16_pkg::*;
#(
    parameter int DATA_WIDTH = FP16_W,
    parameter int LEN_WIDTH  = LEN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    output logic                  busy,
    output logic                  done,
    input  logic                  a_empty,
    output logic                  a_r_en,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_empty,
    output logic                  b_r_en,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,
    output logic                  op_first,
    output logic                  op_last
);

    localparam int A_LSB = PAIR_B_LSB + DATA_WIDTH;
    localparam int PW    = A_LSB + DATA_WIDTH;
    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] issued_q, issued_d;
    logic [LEN_WIDTH-1:0] delivered_q, delivered_d;
    logic [LEN_WIDTH-1:0] tag_q;
    logic                 inflight_q;
    logic                 done_q, done_d;
    logic [1:0]           skid_cnt;
    logic [PW-1:0]        skid_din;
    logic [PW-1:0]        skid_dout;
    logic [2:0]           occ;
    logic                 pop;
    logic                 deq;

    assign op_valid = (skid_cnt != 2'd0);
    assign deq      = op_valid && op_ready;

    // Slots already committed: buffered pairs plus the read still in flight.
    assign occ = {1'b0, skid_cnt} + {2'b0, inflight_q} - {2'b0, deq};
    assign pop = (state_q == ST_RUN) && !a_empty && !b_empty
              && (issued_q < len_q) && (occ < 3'd2);

    assign a_r_en = pop;
    assign b_r_en = pop;
    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;

    assign skid_din = {a_data, b_data,
                       (tag_q == '0), (tag_q == len_q - ONE)};

    fp16_pair_skid #(
        .W(PW)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push_i(inflight_q),
        .pop_i (deq),
        .din_i (skid_din),
        .dout_o(skid_dout),
        .cnt_o (skid_cnt)
    );

    assign op_a     = skid_dout[A_LSB +: DATA_WIDTH];
    assign op_b     = skid_dout[PAIR_B_LSB +: DATA_WIDTH];
    assign op_first = skid_dout[PAIR_FIRST_BIT];
    assign op_last  = skid_dout[PAIR_LAST_BIT];

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        done_d      = 1'b0;
        if (pop) begin
            issued_d = issued_q + ONE;
        end
        if (deq) begin
            delivered_d = delivered_q + ONE;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                        len_d       = cfg_len;
                        issued_d    = '0;
                        delivered_d = '0;
                    end
                end
            end
            ST_RUN: begin
                if (pop && (issued_q + ONE == len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (deq && (delivered_q + ONE == len_q)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            tag_q       <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            inflight_q  <= pop;
            done_q      <= done_d;
            if (pop) begin
                tag_q <= issued_q;
            end
        end
    end

endmodule
